// File: rtl/hw2_alu_pkg.sv
// Shared definitions for the hw2 ALU, its scheduler and the benches around them.
package hw2_alu_pkg;

  localparam int ALU_LAT_DEFAULT = 2;
  localparam int OPND_W          = 8;
  localparam int RES_W           = 16;

  // Opcodes understood by the ALU; the scheduler passes them through untouched.
  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,  // A + B
    OP_SUB   = 3'b001,  // B - A
    OP_MUL   = 3'b010,  // A * B
    OP_AND   = 3'b011,  // A & B
    OP_XOR   = 3'b100,  // A ^ B
    OP_ABS   = 3'b101,  // |A| with A signed, B ignored
    OP_SUBX4 = 3'b110,  // (B - A) * 4 mod 2^16
    OP_RSVD  = 3'b111   // issued and tagged, result is don't-care
  } alu_op_e;

  // One slot of the tag pipe that follows an operation through the ALU.
  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

  // One response FIFO entry: requester id plus the ALU result.
  typedef struct packed {
    logic             id;
    logic [RES_W-1:0] data;
  } rsp_t;

endpackage

// File: rtl/hw2_alu_sched_fifo.sv
// Synchronous response FIFO; the head entry is driven straight from storage.
module hw2_alu_sched_fifo
  import hw2_alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = $bits(rsp_t)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot the simultaneous push needs, even when full.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  // Next pointers and occupancy from this cycle's push/pop.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage, pointers and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (!rst_ni) begin
      // NOTE: storage is reset because the head is visible on the outputs and must read zero out of reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // A push landing on a full FIFO without a pop would silently drop a result.
  always_ff @(posedge clk_i) begin
    if (rst_ni) assert (!(push_i && full_o && !do_pop));
  end

endmodule

// File: rtl/hw2_alu_sched.sv
// Round-robin scheduler sharing one pipelined ALU between two requesters,
// returning id-tagged results in issue order through a credit-protected FIFO.
module hw2_alu_sched
  import hw2_alu_pkg::*;
#(
  parameter int ALU_LAT = ALU_LAT_DEFAULT,
  parameter int DEPTH   = 4
) (
  input  logic              clk_p_i,
  input  logic              reset_n_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [OPND_W-1:0] req0_a_i,
  input  logic [OPND_W-1:0] req0_b_i,
  input  logic [2:0]        req0_inst_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [OPND_W-1:0] req1_a_i,
  input  logic [OPND_W-1:0] req1_b_i,
  input  logic [2:0]        req1_inst_i,
  output logic [OPND_W-1:0] alu_a_o,
  output logic [OPND_W-1:0] alu_b_o,
  output logic [2:0]        alu_inst_o,
  input  logic [RES_W-1:0]  alu_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_id_o,
  output logic [RES_W-1:0]  rsp_data_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic              rr_q, rr_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [OPND_W-1:0] alu_a_q, alu_b_q;
  logic [2:0]        alu_inst_q;
  tag_t              tag_q [ALU_LAT+1];  // index 0 is the tail, ALU_LAT the head

  logic pop, issue_ok, gnt0, gnt1, accept, win_id;
  logic fifo_empty, fifo_full;
  rsp_t push_data, fifo_head;

  assign pop          = rsp_valid_o && rsp_ready_i;
  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_inst_o   = alu_inst_q;
  assign rsp_valid_o  = !fifo_empty;
  assign rsp_id_o     = fifo_head.id;
  assign rsp_data_o   = fifo_head.data;
  assign push_data    = '{id: tag_q[ALU_LAT].id, data: alu_data_i};

  // Arbitration and credit accounting; a pop this cycle lends its credit to an issue.
  always_comb begin
    issue_ok = (outst_q < DEPTH_C) || pop;
    gnt0     = issue_ok && req0_valid_i && (!req1_valid_i || !rr_q);
    gnt1     = issue_ok && req1_valid_i && (!req0_valid_i || rr_q);
    accept   = gnt0 || gnt1;
    win_id   = gnt1;
    rr_d     = accept ? ~win_id : rr_q;
    outst_d  = outst_q;
    if (accept && !pop)      outst_d = outst_q + CW'(1);
    else if (pop && !accept) outst_d = outst_q - CW'(1);
  end

  // Round-robin pointer, credit counter and the operand/opcode issue registers.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_q       <= 1'b0;
      outst_q    <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_inst_q <= '0;
    end else begin
      rr_q    <= rr_d;
      outst_q <= outst_d;
      if (accept) begin
        alu_a_q    <= win_id ? req1_a_i    : req0_a_i;
        alu_b_q    <= win_id ? req1_b_i    : req0_b_i;
        alu_inst_q <= win_id ? req1_inst_i : req0_inst_i;
      end
    end
  end

  // Tag pipe: shifts every cycle so its head lines up with the matching ALU result.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i <= ALU_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{vld: accept, id: win_id};
      for (int i = 1; i <= ALU_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  hw2_alu_sched_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(rsp_t))
  ) u_fifo (
    .clk_i   (clk_p_i),
    .rst_ni  (reset_n_i),
    .push_i  (tag_q[ALU_LAT].vld),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The credit counter covers every FIFO entry, so a full FIFO implies all credits used.
  always_ff @(posedge clk_p_i) begin
    if (reset_n_i) assert (!fifo_full || outst_q == DEPTH_C);
  end

endmodule
